// File: rtl/raster_scan_gen.sv
// rtl/raster_scan_gen.sv - VGA raster sweep, comparator-aligned sync/colour pipeline
//
// Sweeps an H_TOTAL x V_TOTAL raster and presents x/y to an external circle
// comparator. The comparator's registered in_circle comes back COMP_LAT clocks
// later. Raw sync/active decodes are delayed by the same amount, so the rgb,
// hsync, vsync and video_on outputs all describe the same pixel.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous active-low reset
//   pix_en       pixel tick; the raster advances only when high
//   in_circle    comparator result for the x/y presented COMP_LAT clocks earlier
//   x, y         raster counters (0..H_TOTAL-1, 0..V_TOTAL-1)
//   hsync/vsync  active-low syncs, pipeline-aligned with rgb
//   video_on     active-area flag, pipeline-aligned with rgb
//   rgb          pixel colour, 0 in blanking
//   frame_start  one-clock pulse after the raster wraps to (0,0)
//   frame_cnt    completed-frame counter, wraps silently
module raster_scan_gen #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter int          COMP_LAT = 1,
  parameter logic [11:0] FG       = 12'hF00,
  parameter logic [11:0] BG       = 12'h00F
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        in_circle,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [11:0] rgb,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]          x_q, x_d;
  logic [9:0]          y_q, y_d;
  logic                frame_start_q, frame_start_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;

  logic                hs_raw, vs_raw, von_raw;

  // Stage 0 is the newest sample; stage COMP_LAT-1 feeds the output register.
  logic [COMP_LAT-1:0] hs_dly_q, hs_dly_d;
  logic [COMP_LAT-1:0] vs_dly_q, vs_dly_d;
  logic [COMP_LAT-1:0] von_dly_q, von_dly_d;

  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                video_on_q, video_on_d;
  logic [11:0]         rgb_q, rgb_d;

  // Raster counters and frame bookkeeping
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    frame_start_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    if (pix_en) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        if (y_q == V_LAST) begin
          y_d           = '0;
          frame_start_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + 16'd1;
        end else begin
          y_d = y_q + 10'd1;
        end
      end else begin
        x_d = x_q + 10'd1;
      end
    end
  end

  // Raw timing decode of the current raster position
  always_comb begin
    hs_raw  = !((x_q >= HS_START) && (x_q < HS_END));
    vs_raw  = !((y_q >= VS_START) && (y_q < VS_END));
    von_raw = (x_q < H_ACT) && (y_q < V_ACT);
  end

  // Delay line shifts every clock; during pix_en gaps x/y hold, so the
  // repeated samples stay consistent with the comparator's repeated results.
  always_comb begin
    hs_dly_d     = hs_dly_q;
    vs_dly_d     = vs_dly_q;
    von_dly_d    = von_dly_q;
    hs_dly_d[0]  = hs_raw;
    vs_dly_d[0]  = vs_raw;
    von_dly_d[0] = von_raw;
    for (int i = 1; i < COMP_LAT; i++) begin
      hs_dly_d[i]  = hs_dly_q[i-1];
      vs_dly_d[i]  = vs_dly_q[i-1];
      von_dly_d[i] = von_dly_q[i-1];
    end
  end

  // Output stage; in_circle only selects the colour when the aligned
  // sample is active, so blanking never depends on the comparator.
  always_comb begin
    hsync_d    = hs_dly_q[COMP_LAT-1];
    vsync_d    = vs_dly_q[COMP_LAT-1];
    video_on_d = von_dly_q[COMP_LAT-1];
    rgb_d      = 12'h000;
    if (von_dly_q[COMP_LAT-1]) begin
      rgb_d = in_circle ? FG : BG;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
      hs_dly_q      <= '1;
      vs_dly_q      <= '1;
      von_dly_q     <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      rgb_q         <= '0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
      hs_dly_q      <= hs_dly_d;
      vs_dly_q      <= vs_dly_d;
      von_dly_q     <= von_dly_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      rgb_q         <= rgb_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_raster_scan_gen.sv
// tb/tb_raster_scan_gen.sv - self-checking bench for raster_scan_gen
module tb_raster_scan_gen;

  // Default horizontal timing, shortened vertical timing so a frame is 15200 clocks
  localparam int HT    = 800;
  localparam int VT    = 19;
  localparam int FRAME = HT * VT;

  logic        clk;
  logic        reset_n;
  logic        pix_en;
  logic        in_circle;
  logic        force_ic;
  logic [9:0]  x, y;
  logic        hsync, vsync, video_on, frame_start;
  logic [11:0] rgb;
  logic [15:0] frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  raster_scan_gen #(
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut (
    .clk        (clk),
    .reset      (reset_n),
    .pix_en     (pix_en),
    .in_circle  (in_circle),
    .x          (x),
    .y          (y),
    .hsync      (hsync),
    .vsync      (vsync),
    .video_on   (video_on),
    .rgb        (rgb),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator stub: registered match on one pixel, or forced high
  always @(posedge clk) in_circle <= force_ic || (x == 10'd360 && y == 10'd6);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          mx, my;
  logic        ent_rst = 1'b1;
  int          ent_x, ent_y;
  logic        ent_ic;
  logic        e_hs = 1'b1, e_vs = 1'b1, e_von = 1'b0, e_fs = 1'b0;
  logic [11:0] e_rgb = 12'h000;
  logic [15:0] e_fc = 16'h0;
  logic        model_valid = 1'b0;

  always @(posedge clk) begin
    if (!reset_n) begin
      e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0; e_rgb = 12'h000;
      e_fs = 1'b0; e_fc = 16'h0;
      ent_rst = 1'b1; mx = 0; my = 0;
    end else begin
      // Outputs now describe the position sampled one edge ago
      if (ent_rst) begin
        e_hs = 1'b1; e_vs = 1'b1; e_von = 1'b0; e_rgb = 12'h000;
      end else begin
        e_hs  = !(ent_x >= 656 && ent_x < 752);
        e_vs  = !(ent_y >= 14 && ent_y < 16);
        e_von = (ent_x < 640) && (ent_y < 12);
        e_rgb = e_von ? (ent_ic ? 12'hF00 : 12'h00F) : 12'h000;
      end
      ent_rst = 1'b0;
      ent_x   = mx;
      ent_y   = my;
      ent_ic  = force_ic || (mx == 360 && my == 6);
      e_fs    = pix_en && (mx == HT - 1) && (my == VT - 1);
      if (e_fs) e_fc = e_fc + 16'd1;
      if (pix_en) begin
        int p;
        p = (my * HT + mx + 1) % FRAME;
        mx = p % HT;
        my = p / HT;
      end
    end
    model_valid = 1'b1;
  end

  // ---------------- compare process + observation counters ----------------
  int   fg_total = 0, vs_total = 0, fs_total = 0, bad_blank = 0;
  int   fg_x = -1, fg_y = -1;
  int   hs_run = 0, last_hs_run = 0, last_fall_x = -1;
  logic prev_hs = 1'b1;

  always @(negedge clk) begin
    if (model_valid) begin
      check("outputs {x,y,hs,vs,von,rgb,fs,fc}",
            {12'h0, x, y, hsync, vsync, video_on, rgb, frame_start, frame_cnt},
            {12'h0, 10'(mx), 10'(my), e_hs, e_vs, e_von, e_rgb, e_fs, e_fc});
      if (rgb == 12'hF00) begin
        fg_total++; fg_x = int'(x); fg_y = int'(y);
      end
      if (!vsync) vs_total++;
      if (frame_start) fs_total++;
      if (!video_on && rgb != 12'h000) bad_blank++;
      if (!hsync) begin
        if (prev_hs) last_fall_x = int'(x);
        hs_run++;
      end else if (hs_run != 0) begin
        last_hs_run = hs_run;
        hs_run = 0;
      end
      prev_hs = hsync;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int fg0, vs0, fs0;
    logic found;
    reset_n  = 1'b0;
    pix_en   = 1'b1;
    force_ic = 1'b0;

    // Reset values with pix_en high
    repeat (5) tick();
    check("reset_x", 64'(x), 64'd0);
    check("reset_y", 64'(y), 64'd0);
    check("reset_syncs_von", {61'h0, hsync, vsync, video_on}, 64'b110);
    check("reset_rgb", 64'(rgb), 64'd0);
    check("reset_fc_fs", {47'h0, frame_cnt, frame_start}, 64'd0);

    // Line wrap and hsync placement
    reset_n = 1'b1;
    repeat (799) tick();
    check("x_at_799", 64'(x), 64'd799);
    check("y_at_799", 64'(y), 64'd0);
    tick();
    check("wrap_x", 64'(x), 64'd0);
    check("wrap_y", 64'(y), 64'd1);
    check("hsync_fall_x", 64'(last_fall_x), 64'd658);
    check("hsync_low_clks", 64'(last_hs_run), 64'd96);

    // Frame wrap, vsync width, alignment of the single in-circle pixel
    repeat (FRAME - 800) tick();
    check("frame_x", 64'(x), 64'd0);
    check("frame_y", 64'(y), 64'd0);
    check("frame_start_pulse", 64'(frame_start), 64'd1);
    check("frame_cnt_1", 64'(frame_cnt), 64'd1);
    check("vsync_low_clks", 64'(vs_total), 64'd1600);
    check("fg_count", 64'(fg_total), 64'd1);
    check("fg_x", 64'(fg_x), 64'd362);
    check("fg_y", 64'(fg_y), 64'd6);
    tick();
    check("frame_start_one_clk", 64'(frame_start), 64'd0);

    // Comparator forced high: only active pixels may turn FG
    force_ic = 1'b1;
    fg0 = fg_total;
    repeat (2400) tick();
    force_ic = 1'b0;
    repeat (3) tick();
    check("forced_fg_count", 64'(fg_total - fg0), 64'd1920);
    check("blank_rgb_zero", 64'(bad_blank), 64'd0);

    // Pixel-enable gaps: one full frame at half rate
    vs0 = vs_total;
    for (int i = 0; i < 2 * FRAME; i++) begin
      pix_en = ~pix_en;
      tick();
    end
    check("gap_frame_cnt", 64'(frame_cnt), 64'd2);
    check("gap_vsync_low_clks", 64'(vs_total - vs0), 64'd3200);
    check("gap_hsync_low_clks", 64'(last_hs_run), 64'd192);

    // Reset in mid-frame
    found = 1'b0;
    for (int i = 0; i < 20000 && !found; i++) begin
      tick();
      if (x == 10'd10 && y == 10'd10) found = 1'b1;
    end
    check("reach_x10_y10", 64'(found), 64'd1);
    reset_n = 1'b0;
    tick();
    check("midrst_x", 64'(x), 64'd0);
    check("midrst_y", 64'(y), 64'd0);
    check("midrst_fc_fs", {47'h0, frame_cnt, frame_start}, 64'd0);
    reset_n = 1'b1;
    fs0 = fs_total;
    repeat (2000) tick();
    check("resume_x", 64'(x), 64'd400);
    check("resume_y", 64'(y), 64'd2);
    check("no_spurious_frame_start", 64'(fs_total - fs0), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
